dot_product_mac: RTL and testbench

- Streaming signed fixed-point multiply-accumulate; the stage directly upstream of the product rounder.
- Accepts pairs of Q(para_int_bits).(para_frac_bits) operands over a valid/ready handshake.
- Multiplies each pair and accumulates VEC_LEN products into one double-width sum.
- Presents the sum, with an overflow flag, on a valid/ready output whose data width equals the rounder's input width.

---
 rtl/dot_product_mac.sv | 106 ++++++++++
 tb/tb_dot_product_mac.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac.sv
// Streaming signed fixed-point multiply-accumulate producing one 2W-bit dot product per VEC_LEN operand pairs.
// Optional build macro DOT_PRODUCT_MAC_ACC_SAT_EN selects saturating accumulation instead of two's-complement wrap.
module dot_product_mac #(
    parameter int para_int_bits  = 7,
    parameter int para_frac_bits = 9,
    parameter int VEC_LEN        = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          clr,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [para_int_bits+para_frac_bits-1:0]       in_a,
    input  logic [para_int_bits+para_frac_bits-1:0]       in_b,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [2*(para_int_bits+para_frac_bits)-1:0]   out_data,
    output logic                                          out_ovf
);

    localparam int W  = para_int_bits + para_frac_bits;
    localparam int W2 = 2 * W;
    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

    logic [CW-1:0] count;
    logic [W2-1:0] p;
    logic          p_valid;
    logic          p_first;
    logic          p_last;
    logic [W2-1:0] acc;
    logic          sticky_ovf;

    logic          stall;
    logic          accept;
    logic [W2-1:0] product;
    logic [W2-1:0] base;
    logic [W2:0]   sum_ext;
    logic          sum_ovf;
    logic          sticky_next;
    logic [W2-1:0] sum_next;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~rst;
    assign accept   = in_valid & in_ready;
    assign product  = $signed({{W{in_a[W-1]}}, in_a}) * $signed({{W{in_b[W-1]}}, in_b});

    // One guard bit above the 2W range exposes overflow as a disagreement of the top two bits.
    always_comb begin
        base        = p_first ? '0 : acc;
        sum_ext     = {base[W2-1], base} + {p[W2-1], p};
        sum_ovf     = sum_ext[W2] ^ sum_ext[W2-1];
        sticky_next = (p_first ? 1'b0 : sticky_ovf) | sum_ovf;
`ifdef DOT_PRODUCT_MAC_ACC_SAT_EN
        if (sum_ovf)
            sum_next = sum_ext[W2] ? {1'b1, {(W2-1){1'b0}}} : {1'b0, {(W2-1){1'b1}}};
        else
            sum_next = sum_ext[W2-1:0];
`else
        sum_next = sum_ext[W2-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            p          <= '0;
            p_valid    <= 1'b0;
            p_first    <= 1'b0;
            p_last     <= 1'b0;
            acc        <= '0;
            sticky_ovf <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (clr) begin
                count      <= '0;
                p_valid    <= 1'b0;
                sticky_ovf <= 1'b0;
            end else if (!stall) begin
                p_valid <= accept;
                if (accept) begin
                    p       <= product;
                    p_first <= (count == '0);
                    p_last  <= (count == LAST_IDX);
                    count   <= (count == LAST_IDX) ? '0 : count + CW'(1);
                end
                if (p_valid) begin
                    acc        <= sum_next;
                    sticky_ovf <= sticky_next;
                end
            end

            // A new result may replace one being accepted on the same edge, keeping out_valid high.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (!clr && !stall && p_valid && p_last) begin
                out_valid <= 1'b1;
                out_data  <= sum_next;
                out_ovf   <= sticky_next;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac: directed cases plus randomized vectors against an arithmetic model.
// Model honours DOT_PRODUCT_MAC_ACC_SAT_EN the same way the design build does.
module tb_dot_product_mac;

    localparam int VL = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;
    localparam longint RING = 64'sd4294967296;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [15:0] in_a, in_b;
    logic [31:0] out_data;

    logic        s_clr, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf;
    logic [15:0] s_in_a, s_in_b;
    logic [31:0] s_out_data;

    dot_product_mac #(.para_int_bits(7), .para_frac_bits(9), .VEC_LEN(VL)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    dot_product_mac #(.para_int_bits(7), .para_frac_bits(9), .VEC_LEN(1)) dut_single (
        .clk(clk), .rst(rst), .clr(s_clr), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_ovf(s_out_ovf)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data_q[$];
    logic        exp_ovf_q[$];
    longint      acc_m = 0;
    logic        ovf_m = 1'b0;
    int          idx_m = 0;
    int          ready_mode = 0;

    logic        prev_stall = 1'b0;
    logic        prev_rst = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_ovf = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference: exact integer dot product, range-checked against the 32-bit signed result.
    task automatic modelAccept(input logic [15:0] a, input logic [15:0] b);
        longint pa, pb, sum;
        logic [63:0] bits;
        pa = $signed(a);
        pb = $signed(b);
        if (idx_m == 0) begin
            acc_m = 0;
            ovf_m = 1'b0;
        end
        sum = acc_m + pa * pb;
        if (sum > MAXV) begin
            ovf_m = 1'b1;
`ifdef DOT_PRODUCT_MAC_ACC_SAT_EN
            sum = MAXV;
`else
            sum = sum - RING;
`endif
        end else if (sum < MINV) begin
            ovf_m = 1'b1;
`ifdef DOT_PRODUCT_MAC_ACC_SAT_EN
            sum = MINV;
`else
            sum = sum + RING;
`endif
        end
        acc_m = sum;
        if (idx_m == VL - 1) begin
            bits = acc_m;
            exp_data_q.push_back(bits[31:0]);
            exp_ovf_q.push_back(ovf_m);
            idx_m = 0;
        end else begin
            idx_m++;
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Protocol monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_rst) begin
                checkOutput("rst_out_valid", out_valid, 0);
                checkOutput("rst_out_data", out_data, 0);
                checkOutput("rst_out_ovf", out_ovf, 0);
            end
            checkOutput("rst_in_ready", in_ready, 0);
            exp_data_q.delete();
            exp_ovf_q.delete();
            idx_m = 0;
        end else begin
            if (prev_stall && !prev_rst) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, prev_data);
                checkOutput("hold_ovf", out_ovf, prev_ovf);
            end
            checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    checkOutput("out_unexpected", out_valid, 0);
                end else begin
                    checkOutput("out_data", out_data, exp_data_q.pop_front());
                    checkOutput("out_ovf", out_ovf, exp_ovf_q.pop_front());
                end
            end
            if (clr)
                idx_m = 0;
            else if (in_valid && in_ready)
                modelAccept(in_a, in_b);
        end
        prev_stall = out_valid && !out_ready;
        prev_rst   = rst;
        prev_data  = out_data;
        prev_ovf   = out_ovf;
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic applyVector(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < VL; i++)
            applyStimulus(a, b);
    endtask

    // Called right after the last pair is taken: result appears two cycles after it was presented.
    task automatic checkVectorResult(input string tag, input logic [31:0] exp_data, input logic exp_ovf);
        @(negedge clk);
        checkOutput({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_data"}, out_data, exp_data);
        checkOutput({tag, "_ovf"}, out_ovf, exp_ovf);
        @(posedge clk);
        #1;
    endtask

    task automatic waitOutValid();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        checkOutput("out_valid_timeout", out_valid, 1);
    endtask

    function automatic logic [15:0] randOperand();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return r;
        endcase
    endfunction

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        s_clr = 1'b0; s_in_valid = 1'b0; s_in_a = 16'h0400; s_in_b = 16'h0200; s_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // 1.0 * 1.0 summed four times, with latency check.
        applyVector(16'h0200, 16'h0200);
        checkVectorResult("ones", 32'h0010_0000, 1'b0);

        // Negative vector followed immediately by a positive one.
        applyVector(16'hFE00, 16'h0200);
        applyVector(16'h0200, 16'h0200);
        repeat (4) @(posedge clk);
        #1;

        // Most-negative operands overflow the accumulator.
        applyVector(16'h8000, 16'h8000);
`ifdef DOT_PRODUCT_MAC_ACC_SAT_EN
        checkVectorResult("ovf", 32'h7FFF_FFFF, 1'b1);
`else
        checkVectorResult("ovf", 32'h0000_0000, 1'b1);
`endif

        // Backpressure: hold the result while the next vector waits.
        ready_mode = 2;
        applyVector(16'h0300, 16'hFF00);
        waitOutValid();
        @(posedge clk);
        #1;
        fork
            applyVector(16'h0100, 16'h0600);
        join_none
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        ready_mode = 0;
        wait fork;
        repeat (4) @(posedge clk);
        #1;

        // clr mid-vector, with a pair offered during the clr cycle.
        applyStimulus(16'h0200, 16'h0200);
        applyStimulus(16'h0200, 16'h0200);
        clr = 1'b1; in_valid = 1'b1; in_a = 16'h7FFF; in_b = 16'h7FFF;
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0;
        applyVector(16'h0200, 16'h0200);
        checkVectorResult("clr", 32'h0010_0000, 1'b0);

        // rst mid-vector.
        applyStimulus(16'h0200, 16'h0200);
        applyStimulus(16'h0200, 16'h0200);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyVector(16'h0200, 16'h0200);
        checkVectorResult("rst", 32'h0010_0000, 1'b0);

        // Single-element vectors at full throughput.
        s_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("single_idle", s_out_valid, 0);
            if (i >= 2) begin
                checkOutput("single_valid", s_out_valid, 1);
                checkOutput("single_data", s_out_data, 32'h0008_0000);
                checkOutput("single_ovf", s_out_ovf, 0);
                checkOutput("single_in_ready", s_in_ready, 1);
            end
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;

        // Randomized vectors under random backpressure and idle gaps.
        ready_mode = 1;
        for (int v = 0; v < 25; v++) begin
            for (int e = 0; e < VL; e++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                applyStimulus(randOperand(), randOperand());
            end
        end
        ready_mode = 0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("results_drained", exp_data_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
